// File: rtl/ddr5_phy_pkg.sv
// Shared DDR5 controller/PHY definitions: CA command codes, MR addresses,
// MRW request payload and sequencer state encoding.
package ddr5_phy_pkg;

    localparam int unsigned MAX_RANK = 8;
    localparam int unsigned CA_W     = 14;

    localparam logic [4:0] CMD_MRW   = 5'b00101;
    localparam logic [4:0] CMD_WR_RD = 5'b01101;

    localparam logic [7:0] MA_MR0  = 8'd0;
    localparam logic [7:0] MA_MR8  = 8'd8;
    localparam logic [7:0] MA_MR50 = 8'd50;

    // Rank field is sized for the widest supported configuration; the
    // sequencer only consumes the low pNUM_RANK bits.
    typedef struct packed {
        logic [MAX_RANK-1:0] rank;
        logic [7:0]          ma;
        logic [7:0]          op;
        logic                cw;
    } mrw_req_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD1 = 2'd1,
        ST_CMD2 = 2'd2,
        ST_GAP  = 2'd3
    } mrw_state_e;

    function automatic logic [CA_W-1:0] mrw_cmd1_ca(input logic [7:0] ma);
        return {1'b0, ma, CMD_MRW};
    endfunction

    function automatic logic [CA_W-1:0] mrw_cmd2_ca(input logic [7:0] op, input logic cw);
        return {3'b000, cw, 2'b00, op};
    endfunction

endpackage

// File: rtl/ddr5_mrw_req_fifo.sv
// Synchronous request FIFO for MRW commands; power-of-two depth so the
// pointers wrap naturally.
module ddr5_mrw_req_fifo
    import ddr5_phy_pkg::*;
#(
    parameter int unsigned pDEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  mrw_req_t push_data_i,
    input  logic     pop_i,
    output mrw_req_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PTR_W = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(pDEPTH) + 1;

    mrw_req_t           mem [pDEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push_ok;
    logic               pop_ok;

    assign full_o  = (count == CNT_W'(pDEPTH));
    assign empty_o = (count == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin : p_mem
        if (push_ok) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    // Full-check uses the pre-pop count, so a push while full is refused even
    // if the same cycle pops.
    always_ff @(posedge clk_i or negedge rst_i) begin : p_ptr
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr5_mc_mrw_sequencer.sv
// Controller-side MRW initiator: queues requests, drives the two-cycle MRW
// encoding on the DFI CA bus with a tMRW gap, and shadows MR0/MR8/MR50.
module ddr5_mc_mrw_sequencer
    import ddr5_phy_pkg::*;
#(
    parameter int unsigned pNUM_RANK = 1,
    parameter int unsigned pQ_DEPTH  = 4,
    parameter int unsigned pTMRW     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [pNUM_RANK-1:0] req_rank_i,
    input  logic [7:0]           req_ma_i,
    input  logic [7:0]           req_op_i,
    input  logic                 req_cw_i,
    output logic [pNUM_RANK-1:0] dfi_cs_o,
    output logic [CA_W-1:0]      dfi_address_o,
    output logic                 busy_o,
    output logic [7:0]           shadow_mr0_o,
    output logic [7:0]           shadow_mr8_o,
    output logic [7:0]           shadow_mr50_o
);

    mrw_state_e             state_q, state_d;
    logic [7:0]             gap_q, gap_d;
    logic [7:0]             work_ma_q, work_ma_d;
    logic [7:0]             work_op_q, work_op_d;
    logic                   work_cw_q, work_cw_d;
    logic [pNUM_RANK-1:0]   cs_d;
    logic [CA_W-1:0]        ca_d;
    logic                   launch_ok;
    logic                   pop;
    logic                   full;
    logic                   empty;
    mrw_req_t               push_req;
    mrw_req_t               head;

    always_comb begin : p_push_pack
        push_req      = '0;
        push_req.rank = MAX_RANK'(req_rank_i);
        push_req.ma   = req_ma_i;
        push_req.op   = req_op_i;
        push_req.cw   = req_cw_i;
    end

    ddr5_mrw_req_fifo #(
        .pDEPTH (pQ_DEPTH)
    ) u_req_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (req_valid_i),
        .push_data_i (push_req),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    if (pNUM_RANK < MAX_RANK) begin : g_rank_pad
        logic unused_rank_bits;
        assign unused_rank_bits = ^head.rank[MAX_RANK-1:pNUM_RANK];
    end

    assign req_ready_o = ~full;
    assign busy_o      = (state_q != ST_IDLE) | ~empty;

    // Next state and next CA/CS values; the last GAP cycle (or CMD2 with no
    // gap) may launch the next CMD1 directly so the idle run is exactly tMRW.
    always_comb begin : p_next
        state_d   = state_q;
        gap_d     = gap_q;
        work_ma_d = work_ma_q;
        work_op_d = work_op_q;
        work_cw_d = work_cw_q;
        cs_d      = '1;
        ca_d      = '0;
        launch_ok = 1'b0;
        pop       = 1'b0;

        case (state_q)
            ST_IDLE: launch_ok = 1'b1;
            ST_CMD1: begin
                state_d = ST_CMD2;
                ca_d    = mrw_cmd2_ca(work_op_q, work_cw_q);
            end
            ST_CMD2: begin
                if (pTMRW > 0) begin
                    state_d = ST_GAP;
                    gap_d   = 8'(pTMRW - 1);
                end else begin
                    state_d   = ST_IDLE;
                    launch_ok = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == 8'd0) begin
                    state_d   = ST_IDLE;
                    launch_ok = 1'b1;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (launch_ok && !empty && enable_i) begin
            state_d   = ST_CMD1;
            pop       = 1'b1;
            work_ma_d = head.ma;
            work_op_d = head.op;
            work_cw_d = head.cw;
            cs_d      = ~head.rank[pNUM_RANK-1:0];
            ca_d      = mrw_cmd1_ca(head.ma);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin : p_state
        if (!rst_i) begin
            state_q       <= ST_IDLE;
            gap_q         <= '0;
            work_ma_q     <= '0;
            work_op_q     <= '0;
            work_cw_q     <= 1'b0;
            dfi_cs_o      <= '1;
            dfi_address_o <= '0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            work_ma_q     <= work_ma_d;
            work_op_q     <= work_op_d;
            work_cw_q     <= work_cw_d;
            dfi_cs_o      <= cs_d;
            dfi_address_o <= ca_d;
        end
    end

    // Shadows track what the DRAM has latched, i.e. after CMD2 completes.
    always_ff @(posedge clk_i or negedge rst_i) begin : p_shadow
        if (!rst_i) begin
            shadow_mr0_o  <= '0;
            shadow_mr8_o  <= '0;
            shadow_mr50_o <= '0;
        end else if (state_q == ST_CMD2) begin
            if (work_ma_q == MA_MR0) begin
                shadow_mr0_o <= work_op_q;
            end
            if (work_ma_q == MA_MR8) begin
                shadow_mr8_o <= work_op_q;
            end
            if (work_ma_q == MA_MR50) begin
                shadow_mr50_o <= work_op_q;
            end
        end
    end

endmodule

// File: tb/tb_ddr5_mc_mrw_sequencer.sv
// Directed bench for the MRW sequencer: stimulus queues expected CA-bus
// cycles, a negedge monitor pops and compares every non-idle cycle.
module tb_ddr5_mc_mrw_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_rank;
    logic [7:0]  req_ma;
    logic [7:0]  req_op;
    logic        req_cw;
    logic [1:0]  dfi_cs;
    logic [13:0] dfi_address;
    logic        busy;
    logic [7:0]  shadow_mr0;
    logic [7:0]  shadow_mr8;
    logic [7:0]  shadow_mr50;

    int n_checks = 0;
    int n_errors = 0;
    int idle_run = 0;

    typedef struct {
        logic [1:0]  cs;
        logic [13:0] ca;
        int          gap;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ddr5_mc_mrw_sequencer #(
        .pNUM_RANK (2),
        .pQ_DEPTH  (4),
        .pTMRW     (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .enable_i      (enable),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_rank_i    (req_rank),
        .req_ma_i      (req_ma),
        .req_op_i      (req_op),
        .req_cw_i      (req_cw),
        .dfi_cs_o      (dfi_cs),
        .dfi_address_o (dfi_address),
        .busy_o        (busy),
        .shadow_mr0_o  (shadow_mr0),
        .shadow_mr8_o  (shadow_mr8),
        .shadow_mr50_o (shadow_mr50)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every non-idle CA/CS cycle must match the next expected entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            idle_run = 0;
        end else if (dfi_cs != 2'b11 || dfi_address != 14'h0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got cs=%0h ca=%0h, expected idle", dfi_cs, dfi_address);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_cs", 32'(dfi_cs), 32'(e.cs));
                chk("sb_ca", 32'(dfi_address), 32'(e.ca));
                if (e.gap >= 0) begin
                    chk("sb_gap", 32'(idle_run), 32'(e.gap));
                end
            end
            idle_run = 0;
        end else begin
            idle_run++;
        end
    end

    // Enqueue one request and its expected CMD1/CMD2 cycles; gap<0 = unchecked.
    task automatic push(input logic [1:0] rank, input logic [7:0] ma, input logic [7:0] op,
                        input logic cw, input logic [1:0] cs1, input logic [13:0] ca1,
                        input logic [13:0] ca2, input int gap);
        logic r;
        bit   done = 0;
        sb.push_back('{cs: cs1, ca: ca1, gap: gap});
        sb.push_back('{cs: 2'b11, ca: ca2, gap: 0});
        req_rank  = rank;
        req_ma    = ma;
        req_op    = op;
        req_cw    = cw;
        req_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            r = req_ready;
            @(posedge clk);
            #1;
            if (r) done = 1;
        end
        req_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: got ready=0 for 200 cycles, expected accept");
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done = 0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(posedge clk);
            #1;
            if (!busy) done = 1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: got busy=1 after %0d cycles, expected 0", max_cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        req_valid = 1'b0;
        req_rank  = '0;
        req_ma    = '0;
        req_op    = '0;
        req_cw    = 1'b0;
        #23;
        chk("rst_cs", 32'(dfi_cs), 32'h3);
        chk("rst_ca", 32'(dfi_address), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mr0", 32'(shadow_mr0), 32'h0);
        chk("rst_mr50", 32'(shadow_mr50), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;

        // MR0 write with latency check
        push(2'b01, 8'd0, 8'h02, 1'b0, 2'b10, 14'h0005, 14'h0002, -1);
        @(negedge clk);
        chk("lat_edge_n", 32'(dfi_cs), 32'h3);
        @(negedge clk);
        chk("lat_cmd1_cs", 32'(dfi_cs), 32'h2);
        chk("lat_cmd1_ca", 32'(dfi_address), 32'h0005);
        wait_idle(50);
        chk("mr0_shadow", 32'(shadow_mr0), 32'h02);

        // MR8 then MR50 back to back: exactly 8 idle cycles between them
        push(2'b01, 8'd8,  8'h18, 1'b0, 2'b10, 14'h0105, 14'h0018, -1);
        push(2'b10, 8'd50, 8'h01, 1'b0, 2'b01, 14'h0645, 14'h0001, 8);
        wait_idle(60);
        chk("b2b_mr8", 32'(shadow_mr8), 32'h18);
        chk("b2b_mr50", 32'(shadow_mr50), 32'h01);
        chk("b2b_mr0_keep", 32'(shadow_mr0), 32'h02);

        // Queue full while blocked, fifth request held until drain starts
        enable = 1'b0;
        push(2'b01, 8'd4, 8'h11, 1'b0, 2'b10, 14'h0085, 14'h0011, -1);
        push(2'b10, 8'd5, 8'h22, 1'b0, 2'b01, 14'h00A5, 14'h0022, 8);
        push(2'b11, 8'd6, 8'h33, 1'b0, 2'b00, 14'h00C5, 14'h0033, 8);
        push(2'b01, 8'd7, 8'h44, 1'b0, 2'b10, 14'h00E5, 14'h0044, 8);
        chk("full_ready", 32'(req_ready), 32'h0);
        chk("full_busy", 32'(busy), 32'h1);
        chk("full_idle_cs", 32'(dfi_cs), 32'h3);
        fork
            push(2'b10, 8'd9, 8'h55, 1'b0, 2'b01, 14'h0125, 14'h0055, 8);
            begin
                repeat (3) @(posedge clk);
                #2;
                chk("full_held", 32'(req_ready), 32'h0);
                enable = 1'b1;
            end
        join
        wait_idle(200);

        // enable dropped during CMD1: CMD2 still issued, next CMD1 waits
        push(2'b01, 8'd8, 8'h5A, 1'b1, 2'b10, 14'h0105, 14'h045A, -1);
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        chk("dis_cmd1_cs", 32'(dfi_cs), 32'h2);
        push(2'b01, 8'd0, 8'h0F, 1'b0, 2'b10, 14'h0005, 14'h000F, -1);
        repeat (15) @(posedge clk);
        #1;
        chk("dis_idle_cs", 32'(dfi_cs), 32'h3);
        chk("dis_pending", 32'(sb.size()), 32'd2);
        chk("dis_mr8", 32'(shadow_mr8), 32'h5A);
        enable = 1'b1;
        wait_idle(50);
        chk("dis_mr0", 32'(shadow_mr0), 32'h0F);

        // Unknown MA leaves shadows untouched
        push(2'b11, 8'd3, 8'hAA, 1'b1, 2'b00, 14'h0065, 14'h04AA, -1);
        wait_idle(50);
        chk("ma3_mr0", 32'(shadow_mr0), 32'h0F);
        chk("ma3_mr8", 32'(shadow_mr8), 32'h5A);
        chk("ma3_mr50", 32'(shadow_mr50), 32'h01);

        // Empty rank mask: still on the CA bus, shadow still updates
        push(2'b00, 8'd50, 8'h7E, 1'b0, 2'b11, 14'h0645, 14'h007E, -1);
        wait_idle(50);
        chk("dry_mr50", 32'(shadow_mr50), 32'h7E);

        // Reset during CMD2 discards the command and the queue
        push(2'b01, 8'd0, 8'h33, 1'b0, 2'b10, 14'h0005, 14'h0033, -1);
        push(2'b01, 8'd8, 8'h44, 1'b0, 2'b10, 14'h0105, 14'h0044, -1);
        @(posedge clk);
        #1;
        chk("rst_pre_cmd2", 32'(dfi_address), 32'h0033);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cs", 32'(dfi_cs), 32'h3);
        chk("rst_mid_ca", 32'(dfi_address), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_mr0", 32'(shadow_mr0), 32'h0);
        chk("post_rst_mr8", 32'(shadow_mr8), 32'h0);
        chk("post_rst_mr50", 32'(shadow_mr50), 32'h0);

        // Normal operation resumes after reset
        push(2'b01, 8'd8, 8'h66, 1'b0, 2'b10, 14'h0105, 14'h0066, -1);
        wait_idle(50);
        chk("resume_mr8", 32'(shadow_mr8), 32'h66);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ddr5_mc_mrw_sequencer.md
Name: ddr5_mc_mrw_sequencer

Overview:
- Controller-side initiator for DDR5 Mode Register Write (MRW) commands on the DFI command/address interface.
- Accepts MRW requests (rank mask, MR address, opcode, CW bit) through a valid/ready queue.
- Emits each request as the two-cycle MRW encoding that ddr5_phy_command_address decodes, and enforces a tMRW gap between commands.
- Keeps shadow copies of MR0/MR8/MR50 so PHY-side burst length, preamble and CRC settings can be cross-checked.

Parameters:
- pNUM_RANK, 1, number of chip-select lines / ranks.
- pQ_DEPTH, 4, request queue depth; power of two, >= 2.
- pTMRW, 8, minimum idle cycles between the CMD2 cycle of one MRW and the CMD1 cycle of the next; range 0..255.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  when low, no new MRW is started.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  queue not full.
- req_rank_i  in  pNUM_RANK  ranks to target; 1 = selected.
- req_ma_i  in  8  mode register address.
- req_op_i  in  8  opcode data.
- req_cw_i  in  1  control-word bit, driven on CA[10] in CMD2.
- dfi_cs_o  out  pNUM_RANK  active-low chip select toward the PHY.
- dfi_address_o  out  14  CA bus toward the PHY.
- busy_o  out  1  queue non-empty or FSM not IDLE.
- shadow_mr0_o  out  8  last OP written to MA=0.
- shadow_mr8_o  out  8  last OP written to MA=8.
- shadow_mr50_o  out  8  last OP written to MA=50.

Behaviour:
- Reset (rst_i low, asynchronous):
  - dfi_cs_o = all ones; dfi_address_o = 0; all shadows = 0.
  - Queue empty; req_ready_o = 1; busy_o = 0; FSM = IDLE; gap counter = 0.
- All DFI outputs are registered.
- Idle encoding: dfi_cs_o all ones, dfi_address_o = 0.
- Queue:
  - Push when req_valid_i & req_ready_o.
  - req_ready_o = !full, combinational from registered count.
  - Push and pop in the same cycle is legal, including when full: the pop frees a slot, but ready still reflects the pre-pop count.
  - Pointers wrap modulo pQ_DEPTH.
- FSM states: IDLE, CMD1, CMD2, GAP.
  - IDLE -> CMD1 when queue non-empty & enable_i. The head entry is popped and latched into the working register.
  - CMD1 (1 cycle):
    - dfi_cs_o = ~rank_mask.
    - dfi_address_o[4:0] = 5'b00101; [12:5] = MA; [13] = 0.
    - Next state CMD2, unconditionally.
  - CMD2 (1 cycle):
    - dfi_cs_o = all ones.
    - dfi_address_o[7:0] = OP; [10] = CW; all other bits 0.
    - Shadow update at the end of this cycle: MA=0 -> shadow_mr0, MA=8 -> shadow_mr8, MA=50 -> shadow_mr50; other MA values leave shadows unchanged.
    - Next state GAP if pTMRW > 0, else back to IDLE-equivalent handling (a new CMD1 may follow immediately if the queue is non-empty and enable_i is high).
  - GAP: outputs idle for exactly pTMRW cycles, then IDLE.
- Latency: a request pushed into an empty queue in IDLE at edge N appears as CMD1 in the cycle after edge N+1; CMD2 follows on the next cycle.
- enable_i low:
  - Only blocks IDLE -> CMD1.
  - An MRW already in CMD1 is never split; CMD2 is always issued.
  - The GAP count continues.
- rank_mask = 0: the command is still issued (cs all ones on CMD1) and shadows still update. This is deliberate so a dry run is visible on the CA bus.
- Reset mid-MRW: outputs go idle immediately; the partially issued command and any queued requests are discarded.
- busy_o = (state != IDLE) | !empty.

Decomposition:
- Shared package ddr5_phy_pkg holds:
  - CMD_MRW = 5'b00101 and CMD_WR_RD = 5'b01101.
  - MA_MR0 = 8'd0, MA_MR8 = 8'd8, MA_MR50 = 8'd50.
  - typedef mrw_req_t {rank, ma, op, cw}.
  - The FSM state enum.
- One sub-module: ddr5_mrw_req_fifo, a synchronous FIFO of mrw_req_t, depth pQ_DEPTH, with full/empty outputs.

Test Plan:
- MR0 write: push MA=0, OP=8'h02, rank=1 -> CMD1: cs=0, addr=14'b00000000000101; CMD2: cs=1, addr=14'h0002; shadow_mr0_o=8'h02; PHY burst_length_o=2.
- MR8 then MR50 back-to-back:
  - Push MA=8, OP=8'h18 and MA=50, OP=8'h01.
  - First CMD1: addr=14'b00000100000101.
  - Exactly pTMRW=8 idle cycles after its CMD2.
  - Second CMD1: addr=14'b00011001000101; its CMD2: addr=14'h0001.
  - shadow_mr50_o=1; PHY dram_crc_en_o=1.
- Queue full: push 5 requests with the FSM blocked by enable_i=0 -> req_ready_o drops after the 4th; the 5th is held; raising enable_i drains them in order with correct gaps.
- enable_i deasserted during CMD1 -> CMD2 is still issued with the correct OP; no further CMD1 until enable_i returns high.
- Reset asserted during CMD2 -> same cycle: dfi_cs_o all ones, dfi_address_o=0, busy_o=0; after release, req_ready_o=1 and shadows=0.
- Unknown MA=8'd3, OP=8'hAA -> CA encodes MA=3 and OP=8'hAA; all three shadows unchanged.
